// File: rtl/fetch_fd_unit.sv
// Fetch stage and F/D pipeline register: PC, delay-slot redirect, hazard stall
// freeze and a saturating count of stalled cycles.
module fetch_fd_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             putoff,
  input  logic             D_jump_en,
  input  logic [31:0]      D_jump_target,
  input  logic [31:0]      F_instr_in,
  output logic [31:0]      F_pc,
  output logic [31:0]      D_instr,
  output logic [31:0]      D_pc,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [31:0] pc;
  logic [31:0] pc_nxt;

  assign F_pc = pc;

  // The instruction at F always enters D, even on a taken redirect (delay slot).
  always_comb begin
    pc_nxt = pc + 32'd4;
    if (D_jump_en) pc_nxt = {D_jump_target[31:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= PC_RESET;
      D_instr   <= 32'h0;
      D_pc      <= 32'h0;
      stall_cnt <= '0;
    end else begin
      if (!putoff) begin
        pc      <= pc_nxt;
        D_instr <= F_instr_in;
        D_pc    <= pc;
      end
      if (putoff && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_fd_unit.sv
// Randomized bench for fetch_fd_unit against a cycle-level behavioural model,
// with directed sequences for delay slot, stall priority, alignment and wrap.
module tb_fetch_fd_unit;
  localparam int          CNT_W = 4;
  localparam logic [31:0] PC_R  = 32'h0000_3000;

  logic             clk = 1'b0;
  logic             reset, putoff, D_jump_en;
  logic [31:0]      D_jump_target, F_instr_in, F_pc, D_instr, D_pc;
  logic [CNT_W-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  // model state
  logic [31:0] m_pc, m_dinstr, m_dpc;
  int          m_cnt;

  always #5 clk = ~clk;

  function automatic logic [31:0] im(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  assign F_instr_in = im(F_pc);

  fetch_fd_unit #(.PC_RESET(PC_R), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .putoff(putoff), .D_jump_en(D_jump_en),
    .D_jump_target(D_jump_target), .F_instr_in(F_instr_in), .F_pc(F_pc),
    .D_instr(D_instr), .D_pc(D_pc), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".F_pc"}, F_pc, m_pc);
    chk({tag, ".D_pc"}, D_pc, m_dpc);
    chk({tag, ".D_instr"}, D_instr, m_dinstr);
    chk({tag, ".cnt"}, {{(32-CNT_W){1'b0}}, stall_cnt}, 32'(m_cnt));
  endtask

  // Apply inputs, take one edge, advance the model, check at the falling edge.
  task automatic step(input logic r, input logic p, input logic j, input logic [31:0] t,
                      input string tag);
    reset = r; putoff = p; D_jump_en = j; D_jump_target = t;
    @(posedge clk);
    if (r === 1'b1) begin
      m_pc = PC_R; m_dinstr = 32'h0; m_dpc = 32'h0; m_cnt = 0;
    end else begin
      if (!p) begin
        m_dpc    = m_pc;
        m_dinstr = im(m_pc);
        m_pc     = j ? (t & 32'hFFFF_FFFC) : m_pc + 32'd4;
      end else if (m_cnt < (1 << CNT_W) - 1) begin
        m_cnt = m_cnt + 1;
      end
    end
    @(negedge clk);
    chk_all(tag);
  endtask

  initial begin
    m_pc = 0; m_dinstr = 0; m_dpc = 0; m_cnt = 0;
    // reset with X on control inputs must still give clean state
    step(1'b1, 1'bx, 1'bx, 32'hx, "rst0");
    step(1'b1, 1'b0, 1'b0, 32'h0, "rst1");
    chk("rst.F_pc", F_pc, 32'h3000);
    chk("rst.D_instr", D_instr, 32'h0);

    // free run
    step(1'b0, 1'b0, 1'b0, 32'h0, "run1");
    chk("run1.D_pc", D_pc, 32'h3000);
    chk("run1.D_instr", D_instr, im(32'h3000));
    step(1'b0, 1'b0, 1'b0, 32'h0, "run2");
    chk("run2.F_pc", F_pc, 32'h3008);

    // stall hold
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0, "stall");
    chk("stall.F_pc", F_pc, 32'h3008);
    chk("stall.D_pc", D_pc, 32'h3004);
    chk("stall.cnt", 32'(stall_cnt), 32'd3);

    // taken branch: delay slot enters D, F redirects
    step(1'b0, 1'b0, 1'b1, 32'h3100, "br");
    chk("br.D_pc", D_pc, 32'h3008);
    chk("br.F_pc", F_pc, 32'h3100);
    step(1'b0, 1'b0, 1'b0, 32'h0, "br2");
    chk("br2.D_pc", D_pc, 32'h3100);

    // stall beats redirect
    step(1'b0, 1'b1, 1'b1, 32'h3200, "sbr");
    chk("sbr.F_pc", F_pc, 32'h3104);
    step(1'b0, 1'b0, 1'b1, 32'h3200, "sbr2");
    chk("sbr2.F_pc", F_pc, 32'h3200);

    // misaligned target, then wrap
    step(1'b0, 1'b0, 1'b1, 32'h0000_3203, "mis");
    chk("mis.F_pc", F_pc, 32'h3200);
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, "top");
    step(1'b0, 1'b0, 1'b0, 32'h0, "wrap");
    chk("wrap.F_pc", F_pc, 32'h0);

    // saturation, then reset mid-stall/mid-redirect
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 32'h0, "sat");
    chk("sat.cnt", 32'(stall_cnt), 32'hF);
    step(1'b1, 1'b1, 1'b1, 32'h4000, "rstmid");
    chk("rstmid.F_pc", F_pc, 32'h3000);
    chk("rstmid.D_instr", D_instr, 32'h0);
    chk("rstmid.cnt", 32'(stall_cnt), 32'h0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0), $urandom, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
